// File: rtl/memory_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data has priority; fetch is granted after STARVE_LIMIT consecutive data grants.
module memory_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 i_done,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 stall_IF,
  output logic                 stall_MEM,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e               state_q, state_d;
  logic [3:0]           streak_q, streak_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;

  logic d_req_s;
  logic starve_s;
  logic grant_d_s;
  logic grant_i_s;

  // Grant decision, only meaningful while idle
  always_comb begin
    d_req_s   = d_read | d_write;
    starve_s  = i_req & (streak_q == LIMIT);
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_q == IDLE) begin
      grant_d_s = d_req_s & ~starve_s;
      grant_i_s = ~grant_d_s & i_req;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Next-state, streak counter and transaction latch
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d_s) begin
          state_d = D_BUSY;
          req_d   = 1'b1;
          we_d    = d_write;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (i_req) begin
            streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (grant_i_s) begin
          state_d  = I_BUSY;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = i_addr;
          streak_d = 4'd0;
        end else begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      I_BUSY, D_BUSY: begin
        // Requester-side changes are ignored here; the latch only moves on a grant
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          state_d = state_q;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_done    = (state_q == I_BUSY) & mem_ack;
  assign d_done    = (state_q == D_BUSY) & mem_ack;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign stall_IF  = i_req & ~i_done;
  assign stall_MEM = d_req_s & ~d_done;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: reset, fetch, priority, starvation bound,
// mid-transaction reset and robustness against spurious ack / requester changes.
module tb_memory_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        i_done;
  logic        d_done;
  logic [15:0] i_rdata;
  logic [15:0] d_rdata;
  logic        stall_IF;
  logic        stall_MEM;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks;
  int failures;

  memory_port_arbiter #(.WORD_SIZE(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_done(i_done), .d_done(d_done), .i_rdata(i_rdata), .d_rdata(d_rdata),
    .stall_IF(stall_IF), .stall_MEM(stall_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, stall_IF, stall_MEM} !== 38'd0
          || dut.state_q !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got req=%b we=%b addr=%h wdata=%h idone=%b ddone=%b sif=%b smem=%b state=%0d want all 0",
                 c, mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, stall_IF, stall_MEM, dut.state_q);
      end
    end
  endtask

  task automatic test_single_fetch();
    int busy;
    int stall_cnt;
    int done_cnt;
    bit finished;
    busy = 0; stall_cnt = 0; done_cnt = 0; finished = 1'b0;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    mem_rdata = 16'hBEEF;
    for (int c = 0; c < 12 && !finished; c++) begin
      if (mem_req) busy++;
      mem_ack = mem_req && (busy == 4);
      #1;
      if (stall_IF) stall_cnt++;
      if (mem_req) begin
        checks++;
        if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL fetch_bus got addr=%h we=%b want addr=0010 we=0", mem_addr, mem_we);
        end
      end
      if (i_done) begin
        done_cnt++;
        finished = 1'b1;
        checks++;
        if (i_rdata !== 16'hBEEF) begin
          failures++;
          $display("FAIL fetch_rdata got %h want beef", i_rdata);
        end
      end
      tick();
    end
    i_req = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL fetch_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (stall_cnt !== 4) begin
      failures++;
      $display("FAIL fetch_stall_cycles got %0d want 4", stall_cnt);
    end
    #1;
    checks++;
    if (mem_req !== 1'b0 || i_done !== 1'b0) begin
      failures++;
      $display("FAIL fetch_after got req=%b idone=%b want 0 0", mem_req, i_done);
    end
  endtask

  task automatic test_store_priority();
    i_req   = 1'b1;
    i_addr  = 16'h0010;
    d_write = 1'b1;
    d_addr  = 16'h0020;
    d_wdata = 16'h1234;
    tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234
        || d_done !== 1'b1 || i_done !== 1'b0) begin
      failures++;
      $display("FAIL store_first got req=%b we=%b addr=%h wdata=%h ddone=%b idone=%b want 1 1 0020 1234 1 0",
               mem_req, mem_we, mem_addr, mem_wdata, d_done, i_done);
    end
    tick();
    d_write = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_IF !== 1'b1) begin
      failures++;
      $display("FAIL store_gap got req=%b sif=%b want 0 1", mem_req, stall_IF);
    end
    tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010 || i_done !== 1'b1) begin
      failures++;
      $display("FAIL store_then_fetch got req=%b we=%b addr=%h idone=%b want 1 0 0010 1",
               mem_req, mem_we, mem_addr, i_done);
    end
    tick();
    i_req = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (dut.streak_q !== 4'd0) begin
      failures++;
      $display("FAIL store_streak got %0d want 0", dut.streak_q);
    end
  endtask

  task automatic test_starvation();
    int idx;
    logic exp_i;
    idx = 0;
    i_req  = 1'b1;
    d_read = 1'b1;
    d_addr = 16'h0030;
    mem_rdata = 16'hC0DE;
    for (int c = 0; c < 60 && idx < 15; c++) begin
      mem_ack = mem_req;
      #1;
      if (i_done || d_done) begin
        exp_i = (idx % 5 == 4);
        checks++;
        if (i_done !== exp_i || d_done !== ~exp_i) begin
          failures++;
          $display("FAIL starve_grant idx=%0d got idone=%b ddone=%b want idone=%b", idx, i_done, d_done, exp_i);
        end
        idx++;
      end
      tick();
    end
    mem_ack = 1'b0;
    i_req   = 1'b0;
    d_read  = 1'b0;
    checks++;
    if (idx !== 15) begin
      failures++;
      $display("FAIL starve_timeout got %0d grants want 15", idx);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    i_req  = 1'b1;
    d_read = 1'b1;
    d_addr = 16'h0040;
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b1 || d_done !== 1'b0 || dut.streak_q !== 4'd1) begin
      failures++;
      $display("FAIL rstmid_busy got req=%b ddone=%b streak=%0d want 1 0 1", mem_req, d_done, dut.streak_q);
    end
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b0 || d_done !== 1'b0 || dut.state_q !== 2'd0 || dut.streak_q !== 4'd0) begin
      failures++;
      $display("FAIL rstmid_after got req=%b ddone=%b state=%0d streak=%0d want 0 0 0 0",
               mem_req, d_done, dut.state_q, dut.streak_q);
    end
    reset  = 1'b0;
    i_req  = 1'b0;
    d_read = 1'b0;
    tick();
  endtask

  task automatic test_robustness();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (i_done !== 1'b0 || d_done !== 1'b0) begin
      failures++;
      $display("FAIL spurious_ack got idone=%b ddone=%b want 0 0", i_done, d_done);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || dut.state_q !== 2'd0) begin
      failures++;
      $display("FAIL spurious_state got req=%b state=%0d want 0 0", mem_req, dut.state_q);
    end
    d_write = 1'b1;
    d_addr  = 16'h0055;
    d_wdata = 16'hA5A5;
    tick();
    d_addr  = 16'h0077;
    d_wdata = 16'h0000;
    tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_addr !== 16'h0055 || mem_wdata !== 16'hA5A5 || mem_we !== 1'b1 || d_done !== 1'b1) begin
      failures++;
      $display("FAIL hold_latch got addr=%h wdata=%h we=%b ddone=%b want 0055 a5a5 1 1",
               mem_addr, mem_wdata, mem_we, d_done);
    end
    tick();
    mem_ack = 1'b0;
    d_write = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_MEM !== 1'b0) begin
      failures++;
      $display("FAIL robust_end got req=%b smem=%b want 0 0", mem_req, stall_MEM);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = 16'h0000;
    d_read = 1'b0; d_write = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    test_reset();
    test_single_fetch();
    test_store_priority();
    test_starvation();
    test_reset_mid();
    test_robustness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the data-memory stage of the pipelined CPU. Arbitrates requests, sequences one memory transaction at a time over a req/ack handshake, and returns per-requester completion pulses. Also produces the `stall_IF` / `stall_MEM` signals consumed by the hazard logic, so the pipeline freezes while an access is outstanding. Data accesses have priority, with a bounded-starvation guarantee for fetch.

## Interface
- `WORD_SIZE`, 16, data and address width
- `STARVE_LIMIT`, 4, consecutive data grants allowed while fetch waits (1..15)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  fetch request; held until `i_done`
- `i_addr`  in  WORD_SIZE  fetch address
- `d_read`, `d_write`  in  1 each  data load / store request; held until `d_done`
- `d_addr`, `d_wdata`  in  WORD_SIZE  data address / store data
- `i_done`, `d_done`  out  1  completion pulse, one cycle
- `i_rdata`, `d_rdata`  out  WORD_SIZE  read data, valid only with the matching done
- `stall_IF`, `stall_MEM`  out  1  stage must hold
- `mem_req`  out  1  transaction active
- `mem_we`  out  1  write transaction
- `mem_addr`, `mem_wdata`  out  WORD_SIZE  registered transaction address / data
- `mem_ack`  in  1  memory completion, one cycle; qualified by `mem_req`
- `mem_rdata`  in  WORD_SIZE  read data, valid with `mem_ack`

## Operation
- States: IDLE, I_BUSY, D_BUSY (2-bit register).
- `d_req = d_read | d_write`. If both are asserted, the access is treated as a write, and `d_rdata` is don't-care.
- IDLE, at the clock edge:
  - If `d_req` and not (`i_req` and `streak == STARVE_LIMIT`), go to D_BUSY and latch `d_addr`, `d_wdata`, and `we = d_write`.
  - Otherwise, if `i_req`, go to I_BUSY, latch `i_addr`, and set `we = 0`.
  - Otherwise, stay in IDLE.
- Starvation counter `streak` (4 bits):
  - On a data grant with `i_req` high: `streak + 1`, saturating at 15.
  - On a data grant with `i_req` low: cleared to 0.
  - On a fetch grant: cleared to 0.
- I_BUSY / D_BUSY:
  - `mem_req = 1`. `mem_addr`, `mem_wdata`, and `mem_we` come from the latched registers and are stable for the whole transaction.
  - On `mem_ack`, return to IDLE.
- Done pulses and read data:
  - `i_done = (state == I_BUSY) & mem_ack` and `d_done = (state == D_BUSY) & mem_ack`. Both are combinational.
  - `i_rdata` and `d_rdata` pass `mem_rdata` through.
- Stalls:
  - `stall_IF = i_req & ~i_done`.
  - `stall_MEM = d_req & ~d_done`.
- Requester changes to address or data during a transaction are ignored until the next grant.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values: state IDLE, `streak` 0, latched registers 0. All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, the done pulses, and the stalls (given requests low).
- Reset takes priority over everything. Asserting it mid-transaction drops `mem_req` the next cycle, produces no done pulse, and discards the transaction.
- Latency: request seen in IDLE at edge t. `mem_req` is high from cycle t+1. With zero-wait memory (ack in the first busy cycle), done arrives in cycle t+1, for a 2-cycle access.
- Done completes the transaction at the same edge the requester advances. The next request is sampled in the following IDLE cycle, so there is exactly one IDLE cycle between back-to-back transactions.
- Simultaneous `i_req` and `d_req` in IDLE: data wins unless `streak == STARVE_LIMIT`.
- A request that arrives while busy waits and is evaluated in the next IDLE cycle.
- No combinational path exists from `mem_ack` to `mem_req`.

## Test plan
- Reset / idle: hold `reset` 2 cycles, then release with no requests. All outputs are 0 and the state stays IDLE for 10 cycles.
- Single fetch:
  - Stimulus: `i_req`, `i_addr = 0x0010`, memory acks 3 cycles after `mem_req` rises with `mem_rdata = 0xBEEF`.
  - Response: `mem_addr = 0x0010`, `mem_we = 0`, and `stall_IF` high for 4 cycles. `i_done` pulses once with `i_rdata = 0xBEEF`.
- Store priority:
  - Stimulus: `i_req` and `d_write` asserted together, `d_addr = 0x0020`, `d_wdata = 0x1234`.
  - Response: a D transaction first (`mem_we = 1`, `0x0020` / `0x1234`), then an I transaction after one IDLE cycle.
- Starvation bound:
  - Stimulus: `i_req` held, `d_read` reasserted continuously, zero-wait memory, `STARVE_LIMIT = 4`.
  - Response: exactly 4 D grants, then 1 I grant, with the pattern repeating.
- Reset mid-transaction:
  - Stimulus: `reset` asserted while in D_BUSY, before `mem_ack`.
  - Response: `mem_req` is 0 the next cycle, no `d_done` pulse, state IDLE, `streak` 0.
- Robustness:
  - Stimulus: a spurious `mem_ack` in IDLE, then `d_addr` changed mid-transaction.
  - Response: no done pulse for the spurious ack, and `mem_addr` keeps the latched value.
